// File: rtl/lfsr8_seq_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR stimulus stream.
// It seeds from received data, verifies a run of predictions, and then flags mismatches while locked.
module lfsr8_seq_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          locked,
   output logic          err,
   output logic [CW-1:0] err_count,
   output logic [CW-1:0] word_count,
   output logic [7:0]    expected
);

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
   localparam logic [7:0] LOCKUP   = 8'hFF;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [7:0] nxt(input logic [7:0] p);
      return {p[6:0], ~^{p[7], p[5], p[4], p[3]}};
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
   endfunction

   state_t        state;
   state_t        state_next;
   logic [7:0]    prev;
   logic [7:0]    prev_next;
   logic [3:0]    good;
   logic [3:0]    good_next;
   logic [3:0]    bad;
   logic [3:0]    bad_next;
   logic [7:0]    predicted;
   logic          match;
   logic          lockup;
   logic          good_done;
   logic          bad_done;
   logic          err_next;
   logic          locked_next;
   logic [7:0]    expected_next;
   logic [CW-1:0] err_count_next;
   logic [CW-1:0] word_count_next;

   assign predicted = nxt(prev);
   assign match     = (in_data == predicted);
   assign lockup    = (in_data == LOCKUP);
   assign good_done = ((good + 4'd1) == LOCK_N);
   assign bad_done  = ((bad + 4'd1) == UNLOCK_N);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      if (in_valid) begin
         unique case (state)
            HUNT: begin
               if (!lockup) state_next = VERIFY;
            end
            VERIFY: begin
               if (match) begin
                  if (good_done) state_next = LOCKED;
               end else if (lockup) begin
                  state_next = HUNT;
               end
            end
            LOCKED: begin
               if (!match && bad_done) state_next = HUNT;
            end
            default: state_next = HUNT;
         endcase
      end
   end

   // Datapath next values; idle cycles leave everything untouched.
   always_comb begin
      prev_next       = prev;
      good_next       = good;
      bad_next        = bad;
      err_next        = 1'b0;
      err_count_next  = err_count;
      word_count_next = word_count;
      if (in_valid) begin
         unique case (state)
            HUNT: begin
               if (!lockup) begin
                  prev_next = in_data;
                  good_next = 4'd0;
               end
            end
            VERIFY: begin
               if (match) begin
                  prev_next = in_data;
                  good_next = good + 4'd1;
                  if (good_done) bad_next = 4'd0;
               end else if (!lockup) begin
                  prev_next = in_data;
                  good_next = 4'd0;
               end
            end
            LOCKED: begin
               word_count_next = sat_inc(word_count);
               if (match) begin
                  prev_next = in_data;
                  bad_next  = 4'd0;
               end else begin
                  // Flywheel: keep following the true sequence so one bad word costs one error.
                  prev_next      = predicted;
                  bad_next       = bad + 4'd1;
                  err_next       = 1'b1;
                  err_count_next = sat_inc(err_count);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      locked_next   = (state_next == LOCKED);
      expected_next = (state_next == HUNT) ? 8'h00 : nxt(prev_next);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev       <= 8'h00;
         good       <= 4'd0;
         bad        <= 4'd0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
         expected   <= 8'h00;
      end else begin
         prev       <= prev_next;
         good       <= good_next;
         bad        <= bad_next;
         locked     <= locked_next;
         err        <= err_next;
         err_count  <= err_count_next;
         word_count <= word_count_next;
         expected   <= expected_next;
      end
   end

endmodule

// File: tb/tb_lfsr8_seq_checker.sv
// Directed bench for lfsr8_seq_checker: lock, corruption, unlock, lockup, gaps, reset and saturation.
module tb_lfsr8_seq_checker;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        locked;
   logic        err;
   logic [15:0] err_count;
   logic [15:0] word_count;
   logic [7:0]  expected;
   logic        s_locked;
   logic        s_err;
   logic [3:0]  s_err_count;
   logic [3:0]  s_word_count;
   logic [7:0]  s_expected;

   int checks = 0;
   int errors = 0;

   lfsr8_seq_checker dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .locked     (locked),
      .err        (err),
      .err_count  (err_count),
      .word_count (word_count),
      .expected   (expected)
   );

   lfsr8_seq_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CW(4)) dut_sat (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .locked     (s_locked),
      .err        (s_err),
      .err_count  (s_err_count),
      .word_count (s_word_count),
      .expected   (s_expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pred(input logic [7:0] p);
      return {p[6:0], ~^{p[7], p[5], p[4], p[3]}};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic exp_locked, input logic exp_err,
                       input logic [7:0] exp_pred);
      step(1'b1, d);
      check($sformatf("locked_after_%02h", d), {31'd0, locked}, {31'd0, exp_locked});
      check($sformatf("err_after_%02h", d), {31'd0, err}, {31'd0, exp_err});
      check($sformatf("expected_after_%02h", d), {24'd0, expected}, {24'd0, exp_pred});
   endtask

   task automatic idle(input logic exp_locked, input logic [7:0] exp_pred);
      step(1'b0, 8'h00);
      check("locked_idle", {31'd0, locked}, {31'd0, exp_locked});
      check("err_idle", {31'd0, err}, 32'd0);
      check("expected_idle", {24'd0, expected}, {24'd0, exp_pred});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 8'h00);
      reset = 1'b0;
   endtask

   task automatic check_counts(input string tag, input logic [15:0] ec, input logic [15:0] wc);
      check({tag, "_err_count"}, {16'd0, err_count}, {16'd0, ec});
      check({tag, "_word_count"}, {16'd0, word_count}, {16'd0, wc});
   endtask

   initial begin
      logic [7:0] p;
      logic [7:0] c;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      reset = 1'b0;

      // Reset state
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_expected", {24'd0, expected}, 32'd0);
      check_counts("rst", 16'd0, 16'd0);
      check("rst_sat_err_count", {28'd0, s_err_count}, 32'd0);
      check("rst_sat_expected", {24'd0, s_expected}, 32'd0);

      // Lock from seed: 12 24 48 90 21, locked after 21
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'h24, 1'b0, 1'b0, 8'h48);
      send(8'h48, 1'b0, 1'b0, 8'h90);
      send(8'h90, 1'b0, 1'b0, 8'h21);
      send(8'h21, 1'b1, 1'b0, 8'h42);
      check_counts("lock", 16'd0, 16'd0);

      // Single corruption while locked: 0A replaced by 0B
      send(8'h42, 1'b1, 1'b0, 8'h85);
      send(8'h85, 1'b1, 1'b0, 8'h0A);
      send(8'h0B, 1'b1, 1'b1, 8'h14);
      send(8'h14, 1'b1, 1'b0, 8'h28);
      check_counts("corrupt", 16'd1, 16'd4);

      // Loss of lock: three garbage words, flywheel 28 -> 51 -> A2
      send(8'h00, 1'b1, 1'b1, 8'h51);
      send(8'h00, 1'b1, 1'b1, 8'hA2);
      send(8'h00, 1'b0, 1'b1, 8'h00);
      check_counts("unlock", 16'd4, 16'd7);
      idle(1'b0, 8'h00);
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'h24, 1'b0, 1'b0, 8'h48);
      send(8'h48, 1'b0, 1'b0, 8'h90);
      send(8'h90, 1'b0, 1'b0, 8'h21);
      send(8'h21, 1'b1, 1'b0, 8'h42);
      check_counts("relock", 16'd4, 16'd7);

      // Lockup rejection
      do_reset();
      send(8'hFF, 1'b0, 1'b0, 8'h00);
      send(8'hFF, 1'b0, 1'b0, 8'h00);
      send(8'hFF, 1'b0, 1'b0, 8'h00);
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'h24, 1'b0, 1'b0, 8'h48);
      send(8'h48, 1'b0, 1'b0, 8'h90);
      send(8'h90, 1'b0, 1'b0, 8'h21);
      send(8'h21, 1'b1, 1'b0, 8'h42);
      check_counts("lockup", 16'd0, 16'd0);

      // VERIFY: FF returns to HUNT, other mismatches reseed silently
      do_reset();
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'hFF, 1'b0, 1'b0, 8'h00);
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'h33, 1'b0, 1'b0, 8'h67);
      send(8'h67, 1'b0, 1'b0, 8'hCE);
      send(8'hCE, 1'b0, 1'b0, 8'h9D);
      send(8'h9D, 1'b0, 1'b0, 8'h3A);
      send(8'h3A, 1'b1, 1'b0, 8'h74);
      check_counts("reseed", 16'd0, 16'd0);

      // Valid gaps, then reset together with a valid word while locked
      do_reset();
      send(8'h12, 1'b0, 1'b0, 8'h24);
      idle(1'b0, 8'h24);
      send(8'h24, 1'b0, 1'b0, 8'h48);
      idle(1'b0, 8'h48);
      idle(1'b0, 8'h48);
      send(8'h48, 1'b0, 1'b0, 8'h90);
      send(8'h90, 1'b0, 1'b0, 8'h21);
      idle(1'b0, 8'h21);
      send(8'h21, 1'b1, 1'b0, 8'h42);
      send(8'h42, 1'b1, 1'b0, 8'h85);
      send(8'h84, 1'b1, 1'b1, 8'h0A);
      idle(1'b1, 8'h0A);
      check_counts("gaps", 16'd1, 16'd2);
      reset = 1'b1;
      step(1'b1, 8'h0A);
      reset = 1'b0;
      check("midrst_locked", {31'd0, locked}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_expected", {24'd0, expected}, 32'd0);
      check_counts("midrst", 16'd0, 16'd0);
      send(8'h0A, 1'b0, 1'b0, 8'h14);

      // Saturation: alternate corrupted and clean words while locked
      do_reset();
      send(8'h12, 1'b0, 1'b0, 8'h24);
      send(8'h24, 1'b0, 1'b0, 8'h48);
      send(8'h48, 1'b0, 1'b0, 8'h90);
      send(8'h90, 1'b0, 1'b0, 8'h21);
      send(8'h21, 1'b1, 1'b0, 8'h42);
      p = 8'h21;
      for (int i = 0; i < 20; i++) begin
         c = pred(p);
         send(c ^ 8'h01, 1'b1, 1'b1, pred(c));
         p = c;
         c = pred(p);
         send(c, 1'b1, 1'b0, pred(c));
         p = c;
      end
      check_counts("sat_main", 16'd20, 16'd40);
      check("sat_err_count", {28'd0, s_err_count}, 32'hF);
      check("sat_word_count", {28'd0, s_word_count}, 32'hF);
      check("sat_locked", {31'd0, s_locked}, 32'd1);
      check("sat_expected", {24'd0, s_expected}, {24'd0, pred(p)});
      send(pred(p) ^ 8'h80, 1'b1, 1'b1, pred(pred(p)));
      check("sat_err_hold", {28'd0, s_err_count}, 32'hF);
      check("sat_err_pulse", {31'd0, s_err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr8_seq_checker.md
# lfsr8_seq_checker

Receive-side checker for the 8-bit XNOR LFSR stimulus stream that our regression benches generate. The generator update is crc <= {crc[6:0], ~^{crc[7],crc[5],crc[4],crc[3]}}. The checker accepts one word per valid cycle and self-synchronises to the stream by seeding from received data. It then predicts each following word, declares lock after a run of correct predictions, and counts and flags mismatches while locked. It sits at the consuming end of a generator/DUT path and replaces ad-hoc per-cycle constant compares in benches.

## Interface
- LOCK_CNT, default 4: consecutive correct predictions needed to enter LOCKED. Range 1..15.
- UNLOCK_CNT, default 3: consecutive mismatches while LOCKED that force a return to HUNT. Range 1..15.
- CW, default 16: width of the saturating statistic counters.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- in_valid  in  1  in_data is a stream word this cycle.
- in_data  in  8  received LFSR word.
- locked  out  1  high while in state LOCKED.
- err  out  1  one-cycle pulse: a word received while LOCKED mismatched its prediction.
- err_count  out  CW  mismatches counted while LOCKED; saturates at all-ones.
- word_count  out  CW  valid words counted while LOCKED; saturates at all-ones.
- expected  out  8  prediction for the next valid word; 8'h00 when not seeded.

## Operation
- Prediction function: nxt(p) = {p[6:0], ~^{p[7],p[5],p[4],p[3]}}. Example chain: 12 -> 24 -> 48 -> 90 -> 21.
- 8'hFF is the lockup state (nxt(FF) = FF). It is never accepted as a seed.
- Internal registers: state (HUNT, VERIFY, LOCKED), prev[7:0], good count, bad count.
- Cycles with in_valid = 0 change nothing and produce err = 0.
- HUNT:
  - Valid word != FF: prev <= word, good <= 0, go to VERIFY.
  - Valid word == FF: stay in HUNT.
- VERIFY:
  - Valid word == nxt(prev): prev <= word, good <= good + 1.
  - If good + 1 == LOCK_CNT: go to LOCKED and set bad <= 0.
  - Mismatch with word != FF: reseed with prev <= word and good <= 0. No err pulse, no count change.
  - Mismatch with word == FF: go to HUNT.
- LOCKED: every valid word increments word_count (saturating).
  - Match: prev <= word, bad <= 0.
  - Mismatch: err = 1, err_count increments (saturating), bad <= bad + 1.
  - On mismatch the flywheel holds: prev <= nxt(prev), not the received word. A single corrupted word therefore costs exactly one error.
  - If bad + 1 == UNLOCK_CNT: go to HUNT. prev, word_count and err_count hold their values.
- expected = nxt(prev) in VERIFY and LOCKED, 8'h00 in HUNT.
- Counters are cleared only by reset. Re-locking does not clear them.

## Timing
- All outputs are registered.
- Reset values: locked = 0, err = 0, err_count = 0, word_count = 0, expected = 8'h00, state = HUNT.
- err is high in the cycle after the edge that sampled the offending word. It is never high two cycles from a single word.
- locked rises in the cycle after the edge sampling the LOCK_CNT-th matching word.
  - Minimum time to lock from HUNT is 1 + LOCK_CNT valid words.
- locked falls in the cycle after the edge sampling the UNLOCK_CNT-th consecutive mismatch. That mismatch still pulses err and is still counted.
- Gaps in in_valid do not break the good or bad runs.
- Reset asserted mid-stream wins over any same-cycle valid word. The word is dropped, and the first post-reset word is treated as a HUNT seed.
- Throughput is one word per cycle. There is no backpressure.

## Test plan
- Lock from seed: after reset, send 12,24,48,90,21 back-to-back. Required: locked = 1 in the cycle after 21 is sampled, err never high, err_count = 0, expected = nxt(21) = 42.
- Single corruption while locked: continue the clean chain but replace one word with its bit-0-flipped value. Required: exactly one err pulse, err_count = 1, locked stays 1, next clean word matches with no err.
- Loss of lock: when locked with LOCK_CNT = 4 and UNLOCK_CNT = 3, send three garbage words (00,00,00). Required: err pulses on all three, err_count = 3, locked falls after the third; the following 12 reseeds and the stream relocks after four more matches.
- Lockup rejection: after reset send FF,FF,FF, then 12,24,48,90,21. Required: remains in HUNT through the FFs with expected = 00, then locks exactly as in scenario 1.
- Valid gaps and reset mid-stream: interleave idle cycles into the scenario 1 chain and expect the same lock point. Assert reset together with a valid word while LOCKED. Required: next cycle locked = 0, err_count = 0, word_count = 0, expected = 00.
- Saturation: set CW = 4, lock, then drive 20 mismatches with resync so lock is never lost (alternate bad/good words). Required: err_count holds at 4'hF, no wrap.
